// File: rtl/trena_pkg.sv
// ---------------------------------------------------------------------------
// trena_pkg
// Shared constants for the tape-measure report serializer: the state
// encoding (also exported on db_estado) and the ASCII characters used
// when turning BCD digits into text.
// ---------------------------------------------------------------------------
package trena_pkg;

    // State codes are visible on db_estado, so the numeric values matter.
    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        CARREGA   = 4'd1,
        SELECIONA = 4'd2,
        ENVIA     = 4'd3,
        ESPERA    = 4'd4,
        FINAL     = 4'd5
    } estado_t;

    localparam logic [6:0] ASCII_ZERO = 7'h30;
    localparam logic [6:0] ASCII_ERRO = 7'h3F;
    localparam logic [6:0] ASCII_HASH = 7'h23;

endpackage

// File: rtl/trena_serializador_n_ascii_digito.sv
// ---------------------------------------------------------------------------
// ascii_digito
// Combinational BCD digit to ASCII converter.
//   digito   : 4-bit BCD digit
//   ascii    : '0'..'9' for valid digits, '?' for codes above 9
//   invalido : high when the digit is not a legal BCD value
// ---------------------------------------------------------------------------
module ascii_digito
    import trena_pkg::*;
(
    input  logic [3:0] digito,
    output logic [6:0] ascii,
    output logic       invalido
);

    // Illegal BCD codes are shown as '?' so the operator sees a bad reading.
    always_comb begin
        invalido = (digito > 4'd9);
        if (invalido) begin
            ascii = ASCII_ERRO;
        end else begin
            ascii = ASCII_ZERO + {3'b000, digito};
        end
    end

endmodule

// File: rtl/trena_serializador_n.sv
// ---------------------------------------------------------------------------
// trena_serializador_n
// Captures an NDIG-digit BCD measurement on request and streams it to a
// serial transmitter, most significant digit first, as ASCII characters,
// optionally followed by a terminator character.
//
// Parameters:
//   NDIG          : number of BCD digits (1..8)
//   USA_TERM      : send TERM after the last digit
//   TERM          : terminator character
//   SUPRIME_ZEROS : skip leading zero digits (units digit always sent)
//
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   transmitir    : start request, only honoured while idle
//   medida        : BCD measurement, most significant digit in the MSBs
//   tx_pronto     : transmitter finished the current character
//   tx_partida    : one-cycle start pulse to the transmitter
//   tx_dados      : character being transmitted
//   ocupado       : a report is in progress
//   pronto        : one-cycle pulse when the report is complete
//   erro          : sticky flag, some captured digit was not valid BCD
//   db_estado     : current state code for debug
// ---------------------------------------------------------------------------
module trena_serializador_n
    import trena_pkg::*;
#(
    parameter int         NDIG          = 3,
    parameter bit         USA_TERM      = 1'b1,
    parameter logic [6:0] TERM          = ASCII_HASH,
    parameter bit         SUPRIME_ZEROS = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              transmitir,
    input  logic [4*NDIG-1:0] medida,
    input  logic              tx_pronto,
    output logic              tx_partida,
    output logic [6:0]        tx_dados,
    output logic              ocupado,
    output logic              pronto,
    output logic              erro,
    output logic [3:0]        db_estado
);

    // One extra bit beyond the digit range so that the all-ones value can
    // stand for the terminator slot (idx = -1) below digit 0.
    localparam int            IW       = $clog2(NDIG) + 1;
    localparam logic [IW-1:0] IDX_TERM = '1;
    localparam logic [IW-1:0] IDX_MSD  = IW'(NDIG - 1);

    estado_t           estado;
    estado_t           proximo;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] medida_reg;
    logic [6:0]        dados_reg;
    logic              erro_reg;
    logic              nzero;

    logic [3:0]        digito_sel;
    logic [6:0]        ascii_sel;
    logic              invalido_sel_unused;
    logic [NDIG-1:0]   invalido_vec;
    logic [6:0]        ascii_chk_unused [NDIG];

    logic              is_term;
    logic              ultimo;
    logic              pula;

    // Pick the digit addressed by idx from the latched measurement. In the
    // terminator slot no digit matches and the selection is simply zero.
    always_comb begin
        digito_sel = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                digito_sel = medida_reg[4*i +: 4];
            end
        end
    end

    ascii_digito u_sel (
        .digito   (digito_sel),
        .ascii    (ascii_sel),
        .invalido (invalido_sel_unused)
    );

    // The error check looks at the live input so that erro is already
    // valid in the cycle right after the capture.
    for (genvar g = 0; g < NDIG; g++) begin : g_chk
        ascii_digito u_chk (
            .digito   (medida[4*g +: 4]),
            .ascii    (ascii_chk_unused[g]),
            .invalido (invalido_vec[g])
        );
    end

    // Slot classification: terminator slot, last slot of the report, and
    // whether the current digit is a leading zero that should be skipped.
    always_comb begin
        is_term = (idx == IDX_TERM);
        ultimo  = USA_TERM ? is_term : (idx == '0);
        pula    = SUPRIME_ZEROS && !is_term && !nzero
                  && (digito_sel == 4'd0) && (idx != '0);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state and output decode. Outputs depend only on the state so
    // reset immediately returns them to their idle values.
    always_comb begin
        proximo    = estado;
        tx_partida = 1'b0;
        pronto     = 1'b0;
        ocupado    = 1'b1;
        case (estado)
            INICIAL: begin
                ocupado = 1'b0;
                if (transmitir) begin
                    proximo = CARREGA;
                end
            end
            CARREGA: begin
                proximo = SELECIONA;
            end
            SELECIONA: begin
                if (!pula) begin
                    proximo = ENVIA;
                end
            end
            ENVIA: begin
                tx_partida = 1'b1;
                proximo    = ESPERA;
            end
            ESPERA: begin
                if (tx_pronto) begin
                    proximo = ultimo ? FINAL : SELECIONA;
                end
            end
            FINAL: begin
                pronto  = 1'b1;
                proximo = INICIAL;
            end
            default: begin
                proximo = INICIAL;
            end
        endcase
    end

    // Datapath: capture, digit walk and character register. The character
    // register is only rewritten when leaving SELECIONA, which keeps
    // tx_dados stable for the whole ENVIA/ESPERA window.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx        <= '0;
            medida_reg <= '0;
            dados_reg  <= 7'h00;
            erro_reg   <= 1'b0;
            nzero      <= 1'b0;
        end else begin
            case (estado)
                CARREGA: begin
                    medida_reg <= medida;
                    idx        <= IDX_MSD;
                    erro_reg   <= |invalido_vec;
                    nzero      <= 1'b0;
                end
                SELECIONA: begin
                    if (pula) begin
                        idx <= idx - IW'(1);
                    end else begin
                        dados_reg <= is_term ? TERM : ascii_sel;
                        nzero     <= 1'b1;
                    end
                end
                ESPERA: begin
                    if (tx_pronto && !ultimo) begin
                        idx <= idx - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_dados  = dados_reg;
    assign erro      = erro_reg;
    assign db_estado = estado;

endmodule

// File: tb/tb_trena_serializador_n.sv
// ---------------------------------------------------------------------------
// tb_trena_serializador_n
// Three serializer configurations driven in lockstep:
//   dut0 : NDIG=3, terminator, no zero suppression
//   dut1 : NDIG=3, terminator, leading-zero suppression
//   dut2 : NDIG=5, no terminator, no zero suppression
// Each has its own transmitter model and monitor; expected characters are
// queued per configuration when a report is requested.
// ---------------------------------------------------------------------------
module tb_trena_serializador_n;

    logic        clock;
    logic        reset;
    logic        transmitir;
    logic [11:0] medida0;
    logic [11:0] medida1;
    logic [19:0] medida2;

    logic        txPronto  [3];
    logic        txPartida [3];
    logic [6:0]  txDados   [3];
    logic        ocupado   [3];
    logic        pronto    [3];
    logic        erro      [3];
    logic [3:0]  dbEstado  [3];

    int          ndCfg [3] = '{3, 3, 5};
    bit          utCfg [3] = '{1'b1, 1'b1, 1'b0};
    bit          szCfg [3] = '{1'b0, 1'b1, 1'b0};

    logic [6:0]  expq [3][$];
    bit          expErro [3];
    int          partidas [3];
    int          prontos [3];
    int          checks = 0;
    int          errors = 0;

    trena_serializador_n #(.NDIG(3), .USA_TERM(1'b1), .TERM(7'h23), .SUPRIME_ZEROS(1'b0)) dut0 (
        .clock(clock), .reset(reset), .transmitir(transmitir), .medida(medida0),
        .tx_pronto(txPronto[0]), .tx_partida(txPartida[0]), .tx_dados(txDados[0]),
        .ocupado(ocupado[0]), .pronto(pronto[0]), .erro(erro[0]), .db_estado(dbEstado[0])
    );

    trena_serializador_n #(.NDIG(3), .USA_TERM(1'b1), .TERM(7'h23), .SUPRIME_ZEROS(1'b1)) dut1 (
        .clock(clock), .reset(reset), .transmitir(transmitir), .medida(medida1),
        .tx_pronto(txPronto[1]), .tx_partida(txPartida[1]), .tx_dados(txDados[1]),
        .ocupado(ocupado[1]), .pronto(pronto[1]), .erro(erro[1]), .db_estado(dbEstado[1])
    );

    trena_serializador_n #(.NDIG(5), .USA_TERM(1'b0), .TERM(7'h23), .SUPRIME_ZEROS(1'b0)) dut2 (
        .clock(clock), .reset(reset), .transmitir(transmitir), .medida(medida2),
        .tx_pronto(txPronto[2]), .tx_partida(txPartida[2]), .tx_dados(txDados[2]),
        .ocupado(ocupado[2]), .pronto(pronto[2]), .erro(erro[2]), .db_estado(dbEstado[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", nome, got, exp);
        end
    endtask

    // Reference model: the report is the digit list read MSD first, with
    // leading zeros dropped (except units) when suppression is on, each
    // digit written as '0'+d or '?', then the optional terminator.
    function automatic void modelPush(input int g, input logic [19:0] m);
        bit         inicio;
        logic [3:0] d;
        logic [19:0] mm;
        mm          = m;
        inicio      = !szCfg[g];
        expErro[g]  = 1'b0;
        for (int i = ndCfg[g] - 1; i >= 0; i--) begin
            d = mm[4*i +: 4];
            if (d > 4'd9) expErro[g] = 1'b1;
            if (!inicio && d == 4'd0 && i > 0) continue;
            inicio = 1'b1;
            expq[g].push_back((d > 4'd9) ? 7'h3F : (7'h30 + {3'b000, d}));
        end
        if (utCfg[g]) expq[g].push_back(7'h23);
    endfunction

    function automatic logic [19:0] randMedida(input int nd);
        logic [19:0] m;
        int          r;
        m = '0;
        for (int i = 0; i < nd; i++) begin
            r = $urandom_range(0, 21);
            if (r < 10)       m[4*i +: 4] = 4'(r);
            else if (r < 16)  m[4*i +: 4] = 4'd0;
            else              m[4*i +: 4] = 4'(r - 6);
        end
        return m;
    endfunction

    // Transmitter models and monitors, one pair per configuration.
    for (genvar g = 0; g < 3; g++) begin : g_tx
        initial begin
            int dly;
            txPronto[g] = 1'b0;
            forever begin
                @(negedge clock);
                if (txPartida[g]) begin
                    txPronto[g] = 1'($urandom_range(0, 1));
                    dly = $urandom_range(0, 4);
                    @(negedge clock);
                    txPronto[g] = 1'b0;
                    repeat (dly) @(negedge clock);
                    txPronto[g] = 1'b1;
                    @(negedge clock);
                    txPronto[g] = 1'b0;
                end else begin
                    txPronto[g] = (dbEstado[g] != 4'd4) && ($urandom_range(0, 7) == 0);
                end
            end
        end

        initial begin
            logic [6:0] e;
            partidas[g] = 0;
            prontos[g]  = 0;
            forever begin
                @(negedge clock);
                if (!reset) begin
                    if (txPartida[g]) begin
                        partidas[g]++;
                        if (expq[g].size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL extra_char_dut%0d got=%0h expected=none", g, txDados[g]);
                        end else begin
                            e = expq[g].pop_front();
                            checkOutput($sformatf("char_dut%0d", g), 32'(txDados[g]), 32'(e));
                        end
                    end
                    if (pronto[g]) begin
                        prontos[g]++;
                        checkOutput($sformatf("chars_left_at_pronto_dut%0d", g), expq[g].size(), 0);
                        checkOutput($sformatf("erro_at_pronto_dut%0d", g), 32'(erro[g]), 32'(expErro[g]));
                    end
                end
            end
        end
    end

    task automatic checkIdle(input string tag);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("%s_estado_dut%0d", tag, g), 32'(dbEstado[g]), 0);
            checkOutput($sformatf("%s_ocupado_dut%0d", tag, g), 32'(ocupado[g]), 0);
            checkOutput($sformatf("%s_partida_dut%0d", tag, g), 32'(txPartida[g]), 0);
            checkOutput($sformatf("%s_dados_dut%0d", tag, g), 32'(txDados[g]), 0);
            checkOutput($sformatf("%s_pronto_dut%0d", tag, g), 32'(pronto[g]), 0);
            checkOutput($sformatf("%s_erro_dut%0d", tag, g), 32'(erro[g]), 0);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] m0, input logic [11:0] m1,
                                 input logic [19:0] m2, input bit perturba);
        int p0 [3];
        int n;
        for (int g = 0; g < 3; g++) p0[g] = prontos[g];
        modelPush(0, {8'h00, m0});
        modelPush(1, {8'h00, m1});
        modelPush(2, m2);
        @(negedge clock);
        medida0    = m0;
        medida1    = m1;
        medida2    = m2;
        transmitir = 1'b1;
        @(negedge clock);
        transmitir = 1'b0;
        checkOutput("latency_carrega", 32'(dbEstado[0]), 1);
        @(negedge clock);
        checkOutput("latency_seleciona", 32'(dbEstado[0]), 2);
        checkOutput("erro_after_carrega", 32'(erro[0]), 32'(expErro[0]));
        @(negedge clock);
        checkOutput("latency_partida", 32'(txPartida[0]), 1);
        if (perturba) begin
            medida0 = 12'($urandom);
            medida1 = 12'($urandom);
            medida2 = 20'($urandom);
            repeat ($urandom_range(1, 6)) @(negedge clock);
            if (ocupado[0] && ocupado[1] && ocupado[2]) begin
                transmitir = 1'b1;
                @(negedge clock);
                transmitir = 1'b0;
            end
        end
        n = 0;
        while ((ocupado[0] || ocupado[1] || ocupado[2]) && n < 600) begin
            @(negedge clock);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("[TB] FAIL report_timeout got=busy expected=idle");
        end
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("pronto_pulses_dut%0d", g), prontos[g] - p0[g], 1);
            checkOutput($sformatf("erro_sticky_dut%0d", g), 32'(erro[g]), 32'(expErro[g]));
            checkOutput($sformatf("chars_missing_dut%0d", g), expq[g].size(), 0);
            expq[g].delete();
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int seen;
        reset      = 1'b1;
        transmitir = 1'b0;
        medida0    = '0;
        medida1    = '0;
        medida2    = '0;
        repeat (3) @(negedge clock);
        checkIdle("reset");
        reset = 1'b0;
        @(negedge clock);
        checkIdle("post_reset");

        applyStimulus(12'h205, 12'h007, 20'h09876, 1'b0);
        applyStimulus(12'h1A3, 12'h000, 20'h00000, 1'b1);
        applyStimulus(12'h999, 12'h100, 20'h50010, 1'b1);

        // Reset while dut0 waits for the second character to finish.
        modelPush(0, 20'h00468);
        modelPush(1, 20'h00048);
        modelPush(2, 20'h12345);
        @(negedge clock);
        medida0    = 12'h468;
        medida1    = 12'h048;
        medida2    = 20'h12345;
        transmitir = 1'b1;
        @(negedge clock);
        transmitir = 1'b0;
        seen = 0;
        n    = 0;
        while (seen < 2 && n < 200) begin
            @(negedge clock);
            n++;
            if (dbEstado[0] == 4'd3) seen++;
        end
        @(negedge clock);
        checkOutput("reach_second_espera", 32'(dbEstado[0]), 4);
        reset = 1'b1;
        @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("midreset_estado_dut%0d", g), 32'(dbEstado[g]), 0);
            checkOutput($sformatf("midreset_ocupado_dut%0d", g), 32'(ocupado[g]), 0);
            checkOutput($sformatf("midreset_partida_dut%0d", g), 32'(txPartida[g]), 0);
            checkOutput($sformatf("midreset_erro_dut%0d", g), 32'(erro[g]), 0);
            expq[g].delete();
        end
        reset = 1'b0;
        repeat (10) @(negedge clock);

        applyStimulus(12'h205, 12'h070, 20'h09876, 1'b0);

        for (int k = 0; k < 30; k++) begin
            applyStimulus(12'(randMedida(3)), 12'(randMedida(3)), randMedida(5),
                          1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
